fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the five-stage forwarding core. It owns the program counter and issues single-outstanding requests to instruction memory. It buffers each returned word with its PC and presents the pair, with a valid flag, to the IF/ID pipeline register. Stalls from the hazard unit hold the buffered pair, and redirects from EX (branch, jump) flush the buffer and discard any stale in-flight response.

## Interface
- XLEN, 32, datapath and address width (taken from the shared `XLEN` define)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  asynchronous, active-low reset
- stall_i  in  1  IF/ID not accepting this cycle (hazard unit)
- redirect_i  in  1  control-flow change from EX
- redirect_pc_i  in  XLEN  redirect target; bits [1:0] are ignored and forced to 0
- imem_req_o  out  1  fetch request
- imem_addr_o  out  XLEN  fetch address; always equals pc_q
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid; cannot be back-pressured
- imem_rdata_i  in  XLEN  instruction word
- pc_o  out  XLEN  PC of the buffered instruction
- inst_o  out  XLEN  buffered instruction
- valid_o  out  1  pc_o/inst_o hold a real instruction
- flush_o  out  1  IF/ID must load a bubble this cycle

## Operation
- Registers:
  - pc_q: next fetch address.
  - state: IDLE, REQ, WAIT or DROP.
  - Output buffer: pc_o, inst_o, valid_o.
- Reset values:
  - state=IDLE, pc_q=RESET_PC.
  - pc_o=0, inst_o=NOP (32'h0000_0013), valid_o=0.
  - imem_req_o=0, flush_o=0.
- imem_req_o = (state==REQ) & (!valid_o | !stall_i) & !redirect_i. A request therefore issues only when the buffer will be empty by response time.
- flush_o = redirect_i (combinational).
- Buffer accept: the buffer drains at the edge when valid_o & !stall_i. If no new response lands in the same cycle, valid_o<=0. When stalled, pc_o, inst_o and valid_o are held.
- State transitions; redirect has the highest priority:
  - IDLE -> REQ after one cycle.
  - REQ: on imem_gnt_i & imem_req_o -> WAIT.
  - WAIT: on imem_rvalid_i, load pc_o<=pc_q, inst_o<=imem_rdata_i, valid_o<=1; set pc_q<=pc_q+4; -> REQ.
  - DROP: on imem_rvalid_i, discard the data -> REQ.
- Redirect, in any state:
  - Effects: valid_o<=0, pc_q<=redirect_pc_i & ~3, flush_o=1.
  - IDLE/REQ -> REQ.
  - WAIT without rvalid in the same cycle -> DROP.
  - WAIT with rvalid in the same cycle: the response is discarded -> REQ.
  - DROP without rvalid -> DROP.
  - DROP with rvalid -> REQ.
- Arithmetic: pc_q+4 wraps modulo 2^XLEN, so 32'hFFFF_FFFC -> 32'h0.
- An imem_rvalid_i arriving in IDLE or REQ is a protocol violation and is ignored.
- Reset mid-operation returns every register to its reset value immediately. The imem is reset by the same rst_ni, so no response survives.

## Timing
- Imem protocol: one outstanding request at a time. Each grant produces exactly one response, no earlier than 1 cycle after the grant. While req=1 and gnt=0, the address may change only on redirect.
- Best-case throughput: one instruction per 2 cycles with a zero-wait memory (gnt in cycle N, rvalid in N+1, next req in N+2).
- Latency: rvalid in cycle N -> valid_o=1 in cycle N+1.
- Redirect: first request to the target occurs in the cycle after the redirect, or after the stale response if one is in flight.

## Structure
- Shared defines file: `XLEN`, `RESET_PC`, the NOP encoding, and the fetch-state encoding (2 bits).
- Single flat module with no sub-module. The PC incrementer and next-state logic are local.

## Test plan
- **Reset and stream:** release reset with gnt=1 and rvalid one cycle after each grant, returning words = address. Required: addresses 0,4,8,...; valid_o pairs (0,0),(4,4),... one every 2 cycles; no request during reset.
- **Stall:** buffer holds (8, word8) and stall_i=1 for 5 cycles. Required: outputs stable, imem_req_o=0 throughout; on release, the next request goes to addr 12.
- **Redirect while waiting:** in WAIT, pulse redirect_i with redirect_pc_i=32'h103. Required: flush_o=1 that cycle, valid_o=0 next cycle, the stale response is discarded in DROP, the next request goes to 32'h100, and its response appears as pc_o=32'h100.
- **Same-cycle redirect and rvalid:** pulse redirect_i in WAIT together with imem_rvalid_i. Required: the response is dropped, the state goes to REQ, and the next address is the target.
- **Wrap-around:** redirect to 32'hFFFF_FFFC. Required: the next fetch address is 32'h0.
- **Async reset mid-fetch:** assert rst_ni low during WAIT, off the clock edge. Required: all outputs return to reset values immediately, and the first request after release goes to RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-unit defines (datapath width, reset PC, NOP, state encoding) and
// the package that turns them into typed constants for the fetch sequencer.
`ifndef FETCH_CTRL_DEFINES
`define FETCH_CTRL_DEFINES
`define XLEN 32
`define RESET_PC 32'h0000_0000
`define NOP_INST 32'h0000_0013
`define FETCH_ST_IDLE 2'd0
`define FETCH_ST_REQ 2'd1
`define FETCH_ST_WAIT 2'd2
`define FETCH_ST_DROP 2'd3
`endif

package fetch_ctrl_pkg;

  localparam logic [31:0] NOP_INST = `NOP_INST;

  typedef enum logic [1:0] {
    FS_IDLE = `FETCH_ST_IDLE,
    FS_REQ  = `FETCH_ST_REQ,
    FS_WAIT = `FETCH_ST_WAIT,
    FS_DROP = `FETCH_ST_DROP
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps one imem request in flight and
// buffers the returned word with its PC for the IF/ID register.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN     = `XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(`RESET_PC)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o,
  output logic            valid_o,
  output logic            flush_o,
  output logic [1:0]      dbg_state_o
);

  // Handshake: a request transfers at a rising edge where imem_req_o and
  // imem_gnt_i are both high; the response (imem_rvalid_i) is single-cycle and
  // cannot be back-pressured. valid_o/stall_i form the IF/ID handoff: the pair
  // on pc_o/inst_o is consumed at an edge where valid_o is high and stall_i low.

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic            valid_q, valid_d;
  logic            imem_req;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    valid_d  = valid_q;
    // Only request when the buffer is guaranteed empty by the time data returns.
    imem_req = (state_q == FS_REQ) && (!valid_q || !stall_i) && !redirect_i;

    if (valid_q && !stall_i) valid_d = 1'b0;

    if (redirect_i) begin
      valid_d = 1'b0;
      pc_d    = {redirect_pc_i[XLEN-1:2], 2'b00};
      case (state_q)
        // An outstanding response becomes stale; it must be swallowed first.
        FS_WAIT, FS_DROP: state_d = imem_rvalid_i ? FS_REQ : FS_DROP;
        default:          state_d = FS_REQ;
      endcase
    end else begin
      case (state_q)
        FS_IDLE: state_d = FS_REQ;
        FS_REQ: begin
          if (imem_req && imem_gnt_i) state_d = FS_WAIT;
        end
        FS_WAIT: begin
          if (imem_rvalid_i) begin
            pc_out_d = pc_q;
            inst_d   = imem_rdata_i;
            valid_d  = 1'b1;
            pc_d     = pc_q + XLEN'(4);
            state_d  = FS_REQ;
          end
        end
        FS_DROP: begin
          if (imem_rvalid_i) state_d = FS_REQ;
        end
        default: state_d = FS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= FS_IDLE;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      inst_q   <= XLEN'(NOP_INST);
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_req_o  = imem_req;
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_out_q;
  assign inst_o      = inst_q;
  assign valid_o     = valid_q;
  assign flush_o     = redirect_i;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by a randomized run, all
// checked against a transaction-level model of the fetch stream and buffer.
module tb_fetch_ctrl;

  localparam int W = 32;
  localparam logic [W-1:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset / DUT ----------------
  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         stall_i = 1'b0;
  logic         redirect_i = 1'b0;
  logic [W-1:0] redirect_pc_i = '0;
  logic         imem_gnt_i = 1'b0;
  logic         imem_rvalid_i = 1'b0;
  logic [W-1:0] imem_rdata_i = '0;
  logic         imem_req_o;
  logic [W-1:0] imem_addr_o;
  logic [W-1:0] pc_o;
  logic [W-1:0] inst_o;
  logic         valid_o;
  logic         flush_o;
  logic [1:0]   dbg_state_o;

  always #5 clk_i = ~clk_i;

  fetch_ctrl dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .valid_o       (valid_o),
    .flush_o       (flush_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  // Memory: one outstanding transaction, response after lat_min..lat_max extra cycles.
  logic [W-1:0] key = '0;
  bit           pend = 0;
  bit           pend_stale = 0;
  logic [W-1:0] pend_addr = '0;
  int           pend_dly = 0;
  int           lat_min = 0;
  int           lat_max = 0;
  logic [W-1:0] exp_q[$];  // every granted fetch address, in order

  // Reference model of the fetch stream and the IF/ID buffer.
  logic [W-1:0] exp_fetch_pc = '0;
  bit           exp_valid = 0;
  logic [W-1:0] exp_pc = '0;
  logic [W-1:0] exp_inst = NOP;
  bit           fresh = 0;
  int           n0;

  function automatic logic [W-1:0] word_at(input logic [W-1:0] a);
    return a ^ key;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called 1 time unit after a rising edge; drives one cycle, checks it, advances.
  task automatic cyc(input bit stall, input bit redir, input logic [W-1:0] rpc, input bit gnt);
    bit           rv, hs, deliver, exp_req;
    logic [W-1:0] addr_s;
    stall_i       = stall;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    imem_gnt_i    = gnt;
    rv            = pend && (pend_dly == 0);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? word_at(pend_addr) : $urandom;
    #2;
    exp_req = !fresh && !pend && !redir && (!exp_valid || !stall);
    chk1("flush", flush_o, redir);
    chk1("req", imem_req_o, exp_req);
    if (exp_req) chk("addr", imem_addr_o, exp_fetch_pc);
    chk1("valid", valid_o, exp_valid);
    chk("pc", pc_o, exp_pc);
    chk("inst", inst_o, exp_inst);
    addr_s  = imem_addr_o;
    hs      = imem_req_o && gnt;
    deliver = rv && !pend_stale && !redir;
    @(posedge clk_i);
    #1;
    fresh = 0;
    if (redir) begin
      exp_valid    = 0;
      exp_fetch_pc = rpc & ~32'h3;
    end else if (deliver) begin
      exp_valid    = 1;
      exp_pc       = pend_addr;
      exp_inst     = word_at(pend_addr);
      exp_fetch_pc = pend_addr + 32'd4;
    end else if (exp_valid && !stall) begin
      exp_valid = 0;
    end
    if (rv) pend = 0;
    else if (pend) begin
      pend_dly--;
      if (redir) pend_stale = 1;
    end
    if (hs) begin
      pend       = 1;
      pend_stale = 0;
      pend_addr  = addr_s;
      pend_dly   = $urandom_range(lat_max, lat_min);
      exp_q.push_back(addr_s);
    end
  endtask

  // Asserts reset off the clock edge and checks outputs return immediately.
  task automatic do_reset();
    #1;
    rst_ni        = 1'b0;
    redirect_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_gnt_i    = 1'b1;
    stall_i       = 1'b0;
    #1;
    chk1("rst_req", imem_req_o, 1'b0);
    chk1("rst_valid", valid_o, 1'b0);
    chk1("rst_flush", flush_o, 1'b0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_inst", inst_o, NOP);
    chk("rst_addr", imem_addr_o, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    chk1("rst_hold_req", imem_req_o, 1'b0);
    rst_ni       = 1'b1;
    pend         = 0;
    pend_stale   = 0;
    exp_fetch_pc = 32'h0;
    exp_valid    = 0;
    exp_pc       = 32'h0;
    exp_inst     = NOP;
    fresh        = 1;
    exp_q.delete();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    @(posedge clk_i);
    #1;

    // Reset and stream: zero-wait memory, word = address.
    key = '0; lat_min = 0; lat_max = 0;
    do_reset();
    repeat (12) cyc(0, 0, '0, 1);
    chk("stream_a0", exp_q[0], 32'h0);
    chk("stream_a1", exp_q[1], 32'h4);
    chk("stream_a2", exp_q[2], 32'h8);
    chk("stream_a3", exp_q[3], 32'hC);

    // Stall with (8, word8) buffered.
    do_reset();
    for (int i = 0; i < 40 && !(exp_valid && exp_pc == 32'h8); i++) cyc(0, 0, '0, 1);
    chk("stall_pc", pc_o, 32'h8);
    chk("stall_inst", inst_o, 32'h8);
    repeat (5) cyc(1, 0, '0, 1);
    chk("stall_hold_pc", pc_o, 32'h8);
    n0 = exp_q.size();
    for (int i = 0; i < 40 && exp_q.size() == n0; i++) cyc(0, 0, '0, 1);
    chk("stall_next_addr", exp_q[$], 32'hC);

    // Redirect while waiting: stale response must be dropped.
    key = $urandom; lat_min = 2; lat_max = 2;
    for (int i = 0; i < 40 && !pend; i++) cyc(0, 0, '0, 1);
    cyc(0, 1, 32'h103, 1);
    chk1("redir_valid_clr", valid_o, 1'b0);
    for (int i = 0; i < 40 && !exp_valid; i++) cyc(0, 0, '0, 1);
    chk("redir_pc", pc_o, 32'h100);
    chk("redir_inst", inst_o, 32'h100 ^ key);
    chk("redir_addr", exp_q[$], 32'h100);

    // Same-cycle redirect and rvalid.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 40 && !(pend && pend_dly == 0); i++) cyc(0, 0, '0, 1);
    cyc(0, 1, 32'h2000, 1);
    chk1("same_valid_clr", valid_o, 1'b0);
    n0 = exp_q.size();
    for (int i = 0; i < 40 && exp_q.size() == n0; i++) cyc(0, 0, '0, 1);
    chk("same_next_addr", exp_q[$], 32'h2000);

    // Wrap-around: low target bits are ignored.
    lat_min = 0; lat_max = 1;
    cyc(0, 1, 32'hFFFF_FFFE, 1);
    for (int i = 0; i < 40 && !(exp_valid && exp_pc == 32'hFFFF_FFFC); i++) cyc(0, 0, '0, 1);
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    n0 = exp_q.size();
    for (int i = 0; i < 40 && exp_q.size() == n0; i++) cyc(0, 0, '0, 1);
    chk("wrap_next_addr", exp_q[$], 32'h0);

    // Async reset mid-fetch.
    lat_min = 2; lat_max = 3;
    cyc(0, 1, 32'h0000_4440, 1);
    for (int i = 0; i < 40 && !pend; i++) cyc(0, 0, '0, 1);
    chk1("wait_reached", pend, 1'b1);
    do_reset();
    n0 = exp_q.size();
    for (int i = 0; i < 40 && exp_q.size() == n0; i++) cyc(0, 0, '0, 1);
    chk("post_reset_addr", exp_q[$], 32'h0);

    // Randomized traffic.
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 8, $urandom,
          $urandom_range(99, 0) < 70);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
